// File: rtl/sel_encode_pkg.sv
// -----------------------------------------------------------------------------
// sel_encode_pkg
//
// Purpose:
//   Shared defaults for the register select/encode stage and its one-hot
//   decoder. The top and the decoder take these as parameter defaults so that
//   a single edit here retargets the whole slice.
//
// Contents:
//   DEF_NUM_REGS     number of general registers (power of two, >= 2)
//   DEF_IMM_W        width of the IR immediate field C
//   DEF_DATA_W       datapath width the immediate is sign-extended to
//   DEF_BA_ZERO_REG  register index that reads as "no register" under BAout
// -----------------------------------------------------------------------------
package sel_encode_pkg;

    localparam int DEF_NUM_REGS    = 16;
    localparam int DEF_IMM_W       = 15;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_BA_ZERO_REG = 0;

endpackage : sel_encode_pkg

// File: rtl/sel_encode_sb_onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
//
// Purpose:
//   Register-index to one-hot decoder with an enable. When en is low every
//   output bit is 0; otherwise exactly the bit selected by idx is 1.
//
// Parameters:
//   NUM_REGS  number of one-hot outputs (power of two)
//   RIDX_W    width of idx
//
// Ports:
//   en      in   1          decode enable
//   idx     in   RIDX_W     register index
//   onehot  out  NUM_REGS   one-hot result (all zero when en=0)
// -----------------------------------------------------------------------------
module onehot_dec
    import sel_encode_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int RIDX_W   = $clog2(NUM_REGS)
) (
    input  logic                en,
    input  logic [RIDX_W-1:0]   idx,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = en && (idx == RIDX_W'(i));
        end
    end

endmodule : onehot_dec

// File: rtl/sel_encode_sb.sv
// -----------------------------------------------------------------------------
// sel_encode_sb
//
// Purpose:
//   Registered register select/encode stage with a per-register busy
//   scoreboard. Picks a register index from the IR fields (Gra > Grb > Grc
//   priority, index 0 when no flag is set), one-hot encodes it into write
//   (Rin) and read (Rout) enables, and sign-extends the IR immediate. A read of
//   a register with a pending write-back is stalled through req_ready/hazard,
//   unless that write-back completes in the same cycle.
//
// Parameters:
//   NUM_REGS, RIDX_W, IMM_W, DATA_W, BA_ZERO_REG (defaults in sel_encode_pkg)
//
// Ports:
//   clock            in   1          rising-edge clock
//   clear            in   1          asynchronous active-low reset
//   req_valid        in   1          request present
//   req_ready        out  1          request accepted this cycle (= !hazard)
//   Gra, Grb, Grc    in   1          register-field selects
//   Rin, Rout, BAout in   1          write enable, read enable, base-address mode
//   claim            in   1          mark the written register busy on accept
//   Ra, Rb, Rc       in   RIDX_W     IR register fields
//   C                in   IMM_W      IR immediate
//   wb_valid         in   1          write-back complete
//   wb_idx           in   RIDX_W     register whose write-back completed
//   out_valid        out  1          registered outputs carry an accepted request
//   RinSignals       out  NUM_REGS   one-hot write enable (registered)
//   RoutSignals      out  NUM_REGS   one-hot read enable (registered)
//   C_sign_extended  out  DATA_W     sign-extended immediate (registered)
//   hazard           out  1          combinational stall indication
//   busy_mask        out  NUM_REGS   scoreboard state
//   pending_cnt      out  RIDX_W+1   popcount of busy_mask (registered)
// -----------------------------------------------------------------------------
module sel_encode_sb
    import sel_encode_pkg::*;
#(
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int RIDX_W      = $clog2(NUM_REGS),
    parameter int IMM_W       = DEF_IMM_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BA_ZERO_REG = DEF_BA_ZERO_REG
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                Gra,
    input  logic                Grb,
    input  logic                Grc,
    input  logic                Rin,
    input  logic                Rout,
    input  logic                BAout,
    input  logic                claim,
    input  logic [RIDX_W-1:0]   Ra,
    input  logic [RIDX_W-1:0]   Rb,
    input  logic [RIDX_W-1:0]   Rc,
    input  logic [IMM_W-1:0]    C,
    input  logic                wb_valid,
    input  logic [RIDX_W-1:0]   wb_idx,
    output logic                out_valid,
    output logic [NUM_REGS-1:0] RinSignals,
    output logic [NUM_REGS-1:0] RoutSignals,
    output logic [DATA_W-1:0]   C_sign_extended,
    output logic                hazard,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [RIDX_W:0]     pending_cnt
);

    localparam logic [RIDX_W-1:0] BA_IDX = RIDX_W'(BA_ZERO_REG);

    // Replicates the immediate's sign bit into the upper datapath bits.
    function automatic logic signed [DATA_W-1:0] sign_ext(input logic signed [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    // Number of set bits; the result width holds NUM_REGS itself, so no wrap.
    function automatic logic [RIDX_W:0] popcount(input logic [NUM_REGS-1:0] m);
        logic [RIDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + (RIDX_W+1)'(m[i]);
        end
        return cnt;
    endfunction

    logic [RIDX_W-1:0]   sel_p0;
    logic                rd_supp_p0;
    logic                fwd_p0;
    logic                hazard_p0;
    logic                acc_p0;
    logic                set_p0;
    logic [NUM_REGS-1:0] rin_oh_p0;
    logic [NUM_REGS-1:0] rout_oh_p0;
    logic [NUM_REGS-1:0] busy_nxt_p0;
    logic [RIDX_W:0]     cnt_nxt_p0;

    logic                vld_p1;
    logic [NUM_REGS-1:0] rin_oh_p1;
    logic [NUM_REGS-1:0] rout_oh_p1;
    logic signed [DATA_W-1:0] csx_p1;
    logic [NUM_REGS-1:0] busy_p1;
    logic [RIDX_W:0]     cnt_p1;

    // ---- p0: selection, hazard and acceptance (combinational) ----
    always_comb begin
        sel_p0 = '0;
        if (Gra) begin
            sel_p0 = Ra;
        end else if (Grb) begin
            sel_p0 = Rb;
        end else if (Grc) begin
            sel_p0 = Rc;
        end
    end

    assign rd_supp_p0 = BAout && (sel_p0 == BA_IDX);
    // A write-back landing this cycle releases its register immediately.
    assign fwd_p0     = wb_valid && (wb_idx == sel_p0);
    assign hazard_p0  = req_valid && Rout && !rd_supp_p0 && busy_p1[sel_p0] && !fwd_p0;
    assign acc_p0     = req_valid && !hazard_p0;
    assign set_p0     = acc_p0 && Rin && claim;

    // Gating the decoders with acc means a rejected cycle registers zeros.
    onehot_dec #(
        .NUM_REGS (NUM_REGS),
        .RIDX_W   (RIDX_W)
    ) u_rin_dec (
        .en     (acc_p0 && Rin),
        .idx    (sel_p0),
        .onehot (rin_oh_p0)
    );

    onehot_dec #(
        .NUM_REGS (NUM_REGS),
        .RIDX_W   (RIDX_W)
    ) u_rout_dec (
        .en     (acc_p0 && Rout && !rd_supp_p0),
        .idx    (sel_p0),
        .onehot (rout_oh_p0)
    );

    // Clear first so that a claim on the same register wins.
    always_comb begin
        busy_nxt_p0 = busy_p1;
        if (wb_valid) begin
            busy_nxt_p0[wb_idx] = 1'b0;
        end
        if (set_p0) begin
            busy_nxt_p0[sel_p0] = 1'b1;
        end
    end

    assign cnt_nxt_p0 = popcount(busy_nxt_p0);

    // ---- p1: registered outputs and scoreboard ----
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            vld_p1     <= 1'b0;
            rin_oh_p1  <= '0;
            rout_oh_p1 <= '0;
            csx_p1     <= '0;
            busy_p1    <= '0;
            cnt_p1     <= '0;
        end else begin
            vld_p1     <= acc_p0;
            rin_oh_p1  <= rin_oh_p0;
            rout_oh_p1 <= rout_oh_p0;
            if (acc_p0) begin
                csx_p1 <= sign_ext(C);
            end
            busy_p1    <= busy_nxt_p0;
            cnt_p1     <= cnt_nxt_p0;
        end
    end

    assign req_ready       = !hazard_p0;
    assign hazard          = hazard_p0;
    assign out_valid       = vld_p1;
    assign RinSignals      = rin_oh_p1;
    assign RoutSignals     = rout_oh_p1;
    assign C_sign_extended = csx_p1;
    assign busy_mask       = busy_p1;
    assign pending_cnt     = cnt_p1;

endmodule : sel_encode_sb

// File: tb/tb_sel_encode_sb.sv
// -----------------------------------------------------------------------------
// tb_sel_encode_sb
//
// Self-checking bench for sel_encode_sb: directed scenarios with literal
// expectations followed by randomized traffic compared every cycle against a
// behavioural model of the scoreboard and encoded outputs.
// -----------------------------------------------------------------------------
module tb_sel_encode_sb;

    localparam int NR  = 16;
    localparam int RW  = 4;
    localparam int IW  = 15;
    localparam int DW  = 32;
    localparam int BAZ = 0;

    logic          clock = 1'b0;
    logic          clear = 1'b0;
    logic          req_valid = 1'b0;
    logic          Gra = 1'b0, Grb = 1'b0, Grc = 1'b0;
    logic          Rin = 1'b0, Rout = 1'b0, BAout = 1'b0, claim = 1'b0;
    logic [RW-1:0] Ra = '0, Rb = '0, Rc = '0;
    logic [IW-1:0] C = '0;
    logic          wb_valid = 1'b0;
    logic [RW-1:0] wb_idx = '0;

    logic          req_ready;
    logic          out_valid;
    logic [NR-1:0] RinSignals;
    logic [NR-1:0] RoutSignals;
    logic [DW-1:0] C_sign_extended;
    logic          hazard;
    logic [NR-1:0] busy_mask;
    logic [RW:0]   pending_cnt;

    always #5 clock = ~clock;

    sel_encode_sb #(
        .NUM_REGS    (NR),
        .RIDX_W      (RW),
        .IMM_W       (IW),
        .DATA_W      (DW),
        .BA_ZERO_REG (BAZ)
    ) dut (
        .clock           (clock),
        .clear           (clear),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .Gra             (Gra),
        .Grb             (Grb),
        .Grc             (Grc),
        .Rin             (Rin),
        .Rout            (Rout),
        .BAout           (BAout),
        .claim           (claim),
        .Ra              (Ra),
        .Rb              (Rb),
        .Rc              (Rc),
        .C               (C),
        .wb_valid        (wb_valid),
        .wb_idx          (wb_idx),
        .out_valid       (out_valid),
        .RinSignals      (RinSignals),
        .RoutSignals     (RoutSignals),
        .C_sign_extended (C_sign_extended),
        .hazard          (hazard),
        .busy_mask       (busy_mask),
        .pending_cnt     (pending_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // cur_* : what the registered outputs must show now
    // nxt_* : what they must show after the coming rising edge
    bit          cur_vld, nxt_vld;
    bit [NR-1:0] cur_rin, nxt_rin, cur_rout, nxt_rout;
    bit [DW-1:0] cur_csx, nxt_csx;
    bit          mbusy [NR];
    bit          nbusy [NR];
    bit          stall_flag = 1'b0;
    int          stall_sel = 0;

    always @(negedge clock) begin : compare
        int sel, cnt;
        bit supp, fwd, hz, acc;
        logic [NR-1:0] bm;
        longint v;

        // Reset is asynchronous: the outputs must already be zero here.
        if (!clear) begin
            cur_vld  = 1'b0;
            cur_rin  = '0;
            cur_rout = '0;
            cur_csx  = '0;
            foreach (mbusy[i]) mbusy[i] = 1'b0;
        end

        cnt = 0;
        for (int i = 0; i < NR; i++) begin
            bm[i] = mbusy[i];
            cnt += int'(mbusy[i]);
        end

        check("out_valid",   64'(out_valid),       64'(cur_vld));
        check("RinSignals",  64'(RinSignals),      64'(cur_rin));
        check("RoutSignals", 64'(RoutSignals),     64'(cur_rout));
        check("C_sext",      64'(C_sign_extended), 64'(cur_csx));
        check("busy_mask",   64'(busy_mask),       64'(bm));
        check("pending_cnt", 64'(pending_cnt),     64'(cnt));

        if (Gra)      sel = int'(Ra);
        else if (Grb) sel = int'(Rb);
        else if (Grc) sel = int'(Rc);
        else          sel = 0;

        supp = BAout && (sel == BAZ);
        fwd  = wb_valid && (int'(wb_idx) == sel);
        hz   = req_valid && Rout && !supp && mbusy[sel] && !fwd;
        acc  = req_valid && !hz;

        check("hazard",    64'(hazard),    64'(hz));
        check("req_ready", 64'(req_ready), 64'(!hz));

        nbusy = mbusy;
        if (!clear) begin
            nxt_vld  = 1'b0;
            nxt_rin  = '0;
            nxt_rout = '0;
            nxt_csx  = '0;
            foreach (nbusy[i]) nbusy[i] = 1'b0;
        end else begin
            nxt_vld  = acc;
            nxt_rin  = (acc && Rin) ? NR'(1 << sel) : '0;
            nxt_rout = (acc && Rout && !supp) ? NR'(1 << sel) : '0;
            if (acc) begin
                v = longint'(C);
                if (v >= 2**(IW-1)) v = v - 2**IW;
                nxt_csx = DW'(v);
            end else begin
                nxt_csx = cur_csx;
            end
            if (wb_valid) nbusy[int'(wb_idx)] = 1'b0;
            if (acc && Rin && claim) nbusy[sel] = 1'b1;
        end
        stall_flag = hz && clear;
        stall_sel  = sel;
    end

    always @(posedge clock) begin
        cur_vld  = nxt_vld;
        cur_rin  = nxt_rin;
        cur_rout = nxt_rout;
        cur_csx  = nxt_csx;
        mbusy    = nbusy;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input bit v, input bit ga, input bit gb, input bit gc,
                       input int ra, input int rb, input int rc,
                       input bit rin, input bit rout, input bit ba, input bit cl,
                       input int c);
        req_valid = v;
        Gra = ga; Grb = gb; Grc = gc;
        Ra = RW'(ra); Rb = RW'(rb); Rc = RW'(rc);
        Rin = rin; Rout = rout; BAout = ba; claim = cl;
        C = IW'(c);
    endtask

    task automatic wb(input bit v, input int idx);
        wb_valid = v;
        wb_idx   = RW'(idx);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_out_valid", 64'(out_valid),       64'd0);
        check("rst_Rin",       64'(RinSignals),      64'd0);
        check("rst_Rout",      64'(RoutSignals),     64'd0);
        check("rst_Csext",     64'(C_sign_extended), 64'd0);
        check("rst_busy",      64'(busy_mask),       64'd0);
        check("rst_pending",   64'(pending_cnt),     64'd0);
        clear = 1'b1;

        // Write R5 with a negative immediate.
        req(1, 1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 'h4000);
        tick();
        check("A_Rin",       64'(RinSignals),      64'h0020);
        check("A_Csext",     64'(C_sign_extended), 64'hFFFF_C000);
        check("A_valid",     64'(out_valid),       64'd1);
        check("A_model_rin", 64'(cur_rin),         64'h0020);
        check("A_model_csx", 64'(cur_csx),         64'hFFFF_C000);

        // Base-address read of R0 is suppressed.
        req(1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        #1 check("B_hazard", 64'(hazard), 64'd0);
        tick();
        check("B_Rout",  64'(RoutSignals), 64'd0);
        check("B_valid", 64'(out_valid),   64'd1);

        // Claim R3, stall a read of it, release by same-cycle write-back.
        req(1, 1, 0, 0, 3, 0, 0, 1, 0, 0, 1, 0);
        tick();
        check("C_busy", 64'(busy_mask), 64'h0008);
        req(1, 0, 0, 1, 0, 0, 3, 0, 1, 0, 0, 0);
        #1;
        check("C_hazard", 64'(hazard),    64'd1);
        check("C_ready",  64'(req_ready), 64'd0);
        tick();
        check("C_stall_valid", 64'(out_valid), 64'd0);
        wb(1, 3);
        #1;
        check("C_fwd_hazard", 64'(hazard),    64'd0);
        check("C_fwd_ready",  64'(req_ready), 64'd1);
        tick();
        check("C_Rout",  64'(RoutSignals), 64'h0008);
        check("C_busy3", 64'(busy_mask[3]), 64'd0);
        wb(0, 0);

        // Claim and write-back of R7 in the same cycle: claim wins.
        req(1, 1, 0, 0, 7, 0, 0, 1, 0, 0, 1, 0);
        wb(1, 7);
        tick();
        check("D_busy7",   64'(busy_mask[7]), 64'd1);
        check("D_pending", 64'(pending_cnt),  64'd1);
        req(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        wb(0, 0);
        check("D_pending0", 64'(pending_cnt), 64'd0);

        // Claim R1, R2, R4, stall on R2, then drop clear mid-cycle.
        req(1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 'h1234);
        tick();
        req(1, 1, 0, 0, 2, 0, 0, 1, 0, 0, 1, 'h1234);
        tick();
        req(1, 1, 0, 0, 4, 0, 0, 1, 0, 0, 1, 'h1234);
        tick();
        check("E_busy",    64'(busy_mask),       64'h0016);
        check("E_pending", 64'(pending_cnt),     64'd3);
        check("E_Csext",   64'(C_sign_extended), 64'h0000_1234);
        req(1, 1, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0);
        #1 check("E_hazard", 64'(hazard), 64'd1);
        tick();
        #2 clear = 1'b0;
        #1;
        check("E_clr_busy",    64'(busy_mask),       64'd0);
        check("E_clr_pending", 64'(pending_cnt),     64'd0);
        check("E_clr_Csext",   64'(C_sign_extended), 64'd0);
        check("E_clr_valid",   64'(out_valid),       64'd0);
        tick();
        clear = 1'b1;
        #1 check("E_rel_ready", 64'(req_ready), 64'd1);
        tick();
        check("E_rel_valid", 64'(out_valid),   64'd1);
        check("E_rel_Rout",  64'(RoutSignals), 64'h0004);

        // Gra outranks Grb.
        req(1, 1, 1, 0, 9, 2, 0, 1, 1, 0, 0, 0);
        tick();
        check("F_Rin",  64'(RinSignals),  64'h0200);
        check("F_Rout", 64'(RoutSignals), 64'h0200);

        // Randomized traffic; the requester holds its inputs while stalled.
        for (int n = 0; n < 3000; n++) begin
            if (!stall_flag) begin
                req_valid = ($urandom_range(0, 4) != 0);
                Gra   = 1'($urandom_range(0, 1));
                Grb   = 1'($urandom_range(0, 1));
                Grc   = 1'($urandom_range(0, 1));
                Ra    = RW'($urandom_range(0, NR-1));
                Rb    = RW'($urandom_range(0, NR-1));
                Rc    = RW'($urandom_range(0, NR-1));
                Rin   = 1'($urandom_range(0, 1));
                Rout  = ($urandom_range(0, 3) != 0);
                BAout = ($urandom_range(0, 3) == 0);
                claim = ($urandom_range(0, 2) == 0);
                C     = IW'($urandom);
            end
            wb_valid = ($urandom_range(0, 2) == 0);
            if (stall_flag && $urandom_range(0, 1) == 1) wb_idx = RW'(stall_sel);
            else wb_idx = RW'($urandom_range(0, NR-1));

            if (n % 300 == 150) clear = 1'b0;
            else if (n % 300 == 151 || n % 300 == 76) clear = 1'b1;
            if (n % 300 == 75) #2 clear = 1'b0;
            tick();
        end

        req(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb(0, 0);
        clear = 1'b1;
        tick();
        tick();
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sel_encode_sb
